// File: rtl/bitsched_pkg.sv
// Shared types and constants for the bitmask scheduler.
package bitsched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Grant index width; never below one bit so single-bit masks still elaborate.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/lsb_extract.sv
// Isolates the lowest set bit of a mask, clears it, and encodes its position.
module lsb_extract
    import bitsched_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] lsb_o,
    output logic [WIDTH-1:0] rest_o,
    output logic [IDX_W-1:0] idx_o
);

    assign lsb_o  = x_i & (-x_i);
    assign rest_o = x_i ^ lsb_o;

    // lsb_o is one-hot or zero, so OR-ing positions gives the exact index.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lsb_o[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bitmask_scheduler.sv
// Issues one grant per set bit of an accepted mask, lowest bit first.
// Optional grant_cnt output is enabled by defining BITSCHED_GRANT_COUNT_EN.
module bitmask_scheduler
    import bitsched_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
`ifdef BITSCHED_GRANT_COUNT_EN
    ,
    output logic [IDX_W:0]   grant_cnt
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] lsb;
    logic [WIDTH-1:0] rest;
    logic [IDX_W-1:0] lsb_idx;
    logic             accept;
    logic             grant_hs;

    lsb_extract #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_lsb (
        .x_i    (rem_q),
        .lsb_o  (lsb),
        .rest_o (rest),
        .idx_o  (lsb_idx)
    );

    // Valid/ready: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and flush blocks both sides for that cycle.
    assign busy       = (state_q == BUSY);
    assign out_valid  = busy;
    assign in_ready   = (state_q == IDLE) && !flush && !rst;
    assign out_onehot = busy ? lsb : '0;
    assign out_idx    = busy ? lsb_idx : '0;
    assign out_last   = busy && (rest == '0);
    assign accept     = in_valid && in_ready;
    assign grant_hs   = out_valid && out_ready && !flush;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (flush) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (accept) begin
            // A zero mask is consumed without leaving IDLE.
            if (in_mask != '0) begin
                state_d = BUSY;
                rem_d   = in_mask;
            end
        end else if (grant_hs) begin
            rem_d = rest;
            if (out_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

`ifdef BITSCHED_GRANT_COUNT_EN
    logic [IDX_W:0] cnt_q, cnt_d;

    // Saturates at WIDTH, the most grants a single mask can produce.
    always_comb begin
        cnt_d = cnt_q;
        if (flush || accept) begin
            cnt_d = '0;
        end else if (grant_hs && (cnt_q != (IDX_W+1)'(WIDTH))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: doc/bitmask_scheduler.md
BITMASK_SCHEDULER -- requirements
Module: bitmask_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 Parameter WIDTH, default 32, SHALL set the request mask width (power of two, 4..64).
REQ-003 Parameter IDX_W, default $clog2(WIDTH), SHALL set the grant index width.
REQ-004 Ports SHALL be:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active high
- flush  input  1  synchronous abort of the current mask
- in_valid  input  1  in_mask is valid
- in_ready  output  1  block accepts a mask
- in_mask  input  WIDTH  request bitmask
- out_valid  output  1  grant is valid
- out_ready  input  1  consumer takes the grant
- out_onehot  output  WIDTH  isolated lowest set bit of the remaining mask
- out_idx  output  IDX_W  binary index of out_onehot
- out_last  output  1  current grant is the final set bit
- busy  output  1  a mask is being scheduled

Function
REQ-005 The FSM SHALL have exactly two states, IDLE and BUSY, plus a WIDTH-bit remaining-mask register rem.
REQ-006 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in BUSY, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-007 On an in_valid && in_ready cycle with in_mask != 0, the block SHALL load rem <= in_mask and go to BUSY; the first grant SHALL be valid on the next cycle (latency 1).
REQ-008 On an accept with in_mask == 0, the mask SHALL be consumed and discarded, and the FSM SHALL stay in IDLE with no output.
REQ-009 In BUSY, out_onehot SHALL equal rem & (-rem), out_idx SHALL be its bit position, and out_last SHALL equal ((rem & (rem-1)) == 0).
REQ-010 On out_valid && out_ready, rem SHALL update to rem ^ (rem & -rem); if out_last was 1, the FSM SHALL return to IDLE on the same edge.
REQ-011 Throughput SHALL be one grant per cycle while out_ready is held at 1; grants SHALL be issued in ascending bit order.
REQ-012 While out_valid && !out_ready, out_onehot, out_idx and out_last SHALL stay stable.
REQ-013 When out_valid is 0, out_onehot and out_idx SHALL be 0.
REQ-014 flush SHALL take priority over both handshakes: rem <= 0 and state <= IDLE; an in_valid in the same cycle SHALL be ignored, and in_ready SHALL be 0 during the flush cycle.
REQ-015 busy SHALL equal (state == BUSY).

Reset
REQ-016 Asserting rst SHALL immediately force state = IDLE and rem = 0, which drives out_valid, out_onehot, out_idx, out_last and busy to 0.
REQ-017 in_ready SHALL be 0 while rst is asserted and 1 from the first cycle after deassertion.
REQ-018 A reset in the middle of a mask SHALL discard all remaining grants.

Configuration
REQ-019 When the macro BITSCHED_GRANT_COUNT_EN is defined, the block SHALL add an output grant_cnt with width IDX_W+1.
- grant_cnt SHALL be 0 at reset and SHALL clear on every accepted mask and on every flush.
- It SHALL increment on each out handshake and SHALL never wrap (maximum WIDTH).
REQ-020 Without BITSCHED_GRANT_COUNT_EN, the grant_cnt port and its register SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-021 A shared package bitsched_pkg SHALL hold:
- the state enum typedef (IDLE, BUSY);
- the default WIDTH constant;
- the index-width function.
REQ-022 A combinational sub-module lsb_extract SHALL compute x & -x, x ^ (x & -x) and the one-hot-to-index encode; bitmask_scheduler SHALL instantiate it once on rem.

Verification
REQ-023 Load in_mask=0x00000028 with out_ready=1 -> the bench SHALL observe grants idx 3 (0x8) then idx 5 (0x20, out_last=1), then in_ready=1 on the next cycle.
REQ-024 Load 0x80000001 with out_ready=0 for 3 cycles -> idx 0 SHALL be held stable for 3 cycles, then idx 0 is taken, then idx 31 is granted with out_last=1.
REQ-025 Load 0x00000000 -> the bench SHALL observe in_ready staying 1 and out_valid never asserting.
REQ-026 Load 0xFFFFFFFF with out_ready=1 -> the bench SHALL observe 32 consecutive grants idx 0..31 with out_last only on 31; with BITSCHED_GRANT_COUNT_EN, grant_cnt SHALL read 32 afterwards.
REQ-027 Load 0x000000F0, take 2 grants, then pulse flush -> out_valid SHALL be 0 on the next cycle, the FSM SHALL be in IDLE, and grant_cnt SHALL be 0.
REQ-028 Run 200 random masks with a random out_ready; the bench SHALL check that every grant matches the reference progression rem ^ (rem & -rem).
REQ-029 Assert rst asynchronously mid-BUSY -> out_valid and busy SHALL drop before the next clock edge.
